// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  function automatic logic cmd_supported(logic [3:0] cmd);
    return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
           (cmd == CMD_CMP) || (cmd == CMD_ORR);
  endfunction

endpackage

// File: rtl/cond_logic.sv
// NZCV flag register, condition decode and gating of the architectural write enables.
module cond_logic
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [3:0] rd,
  input  logic       load_cond,
  input  logic [1:0] flag_w,
  input  logic       next_pc,
  input  logic       branch,
  input  logic       reg_w,
  input  logic       mem_w,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write
);

  logic [3:0] flags;
  logic       cond_ex, cond_ex_reg, pcs;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = ~(n ^ v);
      COND_LT: cond_ex = n ^ v;
      COND_GT: cond_ex = ~z & ~(n ^ v);
      COND_LE: cond_ex = z | (n ^ v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // flag_w is only non-zero in the execute states, so this loads on the edge leaving them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags       <= 4'b0000;
      cond_ex_reg <= 1'b0;
    end else begin
      if (load_cond) cond_ex_reg <= cond_ex;
      if (flag_w[1] & cond_ex_reg) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] & cond_ex_reg) flags[1:0] <= alu_flags[1:0];
    end
  end

  assign pcs       = branch | (reg_w & (rd == 4'hF));
  assign pc_write  = ~reset & (next_pc | (pcs & cond_ex_reg));
  assign reg_write = ~reset & reg_w & cond_ex_reg;
  assign mem_write = ~reset & mem_w & cond_ex_reg;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the ARM-subset core: sequences the shared datapath
// and decodes ALU control, immediate and register-source selects.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] aluFlags,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       memWrite,
  output logic       adrSrc,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] resultSrc,
  output logic [1:0] immSrc,
  output logic [1:0] regSrc,
  output logic [1:0] aluControl,
  output logic       instrDone,
  output logic       illegal
);

  // datapath width does not reach any control port
  logic [31:0] width_unused;
  assign width_unused = 32'(WIDTH);

  state_t     state, state_n;
  logic       next_pc, ir_w, reg_w, mem_w, branch, alu_op, done, ill, load_cond;
  logic [1:0] flag_w;
  logic [3:0] cmd;
  logic       cmd_ok, is_cmp;

  assign cmd    = funct[4:1];
  assign cmd_ok = cmd_supported(cmd);
  assign is_cmp = (cmd == CMD_CMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = FETCH;
    next_pc   = 1'b0;
    ir_w      = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    done      = 1'b0;
    ill       = 1'b0;
    load_cond = 1'b0;
    adrSrc    = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_REG;
    resultSrc = RES_ALUOUT;
    case (state)
      FETCH: begin
        ir_w      = 1'b1;
        next_pc   = 1'b1;
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURESULT;
        state_n   = DECODE;
      end
      DECODE: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURESULT;
        load_cond = 1'b1;
        // an unsupported data-processing cmd still runs to ALUWB, just without a write
        ill       = (op == 2'b11) | ((op == 2'b00) & ~cmd_ok);
        case (op)
          2'b00:   state_n = funct[5] ? EXECI : EXECR;
          2'b01:   state_n = MEMADR;
          2'b10:   state_n = BRANCH;
          default: begin
            state_n = FETCH;
            done    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        aluSrcB = SRCB_IMM;
        state_n = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adrSrc  = 1'b1;
        state_n = MEMWB;
      end
      MEMWB: begin
        resultSrc = RES_DATA;
        reg_w     = 1'b1;
        done      = 1'b1;
      end
      MEMWR: begin
        adrSrc = 1'b1;
        mem_w  = 1'b1;
        done   = 1'b1;
      end
      EXECR: begin
        alu_op  = 1'b1;
        state_n = ALUWB;
      end
      EXECI: begin
        aluSrcB = SRCB_IMM;
        alu_op  = 1'b1;
        state_n = ALUWB;
      end
      ALUWB: begin
        reg_w = cmd_ok & ~is_cmp;
        done  = 1'b1;
      end
      BRANCH: begin
        aluSrcB   = SRCB_IMM;
        resultSrc = RES_ALURESULT;
        branch    = 1'b1;
        done      = 1'b1;
      end
      default: state_n = FETCH;
    endcase
  end

  always_comb begin
    aluControl = ALU_ADD;
    if (alu_op) begin
      case (cmd)
        CMD_ADD:          aluControl = ALU_ADD;
        CMD_SUB, CMD_CMP: aluControl = ALU_SUB;
        CMD_AND:          aluControl = ALU_AND;
        CMD_ORR:          aluControl = ALU_ORR;
        default:          aluControl = ALU_ADD;
      endcase
    end
  end

  assign flag_w[1] = alu_op & (funct[0] | is_cmp);
  assign flag_w[0] = alu_op & (is_cmp | (funct[0] &
                     ((aluControl == ALU_ADD) | (aluControl == ALU_SUB))));

  assign immSrc = op;
  assign regSrc = {op == 2'b01, op == 2'b10};

  assign irWrite   = ~reset & ir_w;
  assign instrDone = ~reset & done;
  assign illegal   = ~reset & ill;

  cond_logic u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (aluFlags),
    .rd        (rd),
    .load_cond (load_cond),
    .flag_w    (flag_w),
    .next_pc   (next_pc),
    .branch    (branch),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .pc_write  (pcWrite),
    .reg_write (regWrite),
    .mem_write (memWrite)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: instruction-level reference model pushes expected per-instruction
// results; a monitor tallies what the controller did and compares on instrDone.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cond, rd, aluFlags;
  logic [1:0] op;
  logic [5:0] funct;
  logic       pcWrite, irWrite, regWrite, memWrite, adrSrc, aluSrcA, instrDone, illegal;
  logic [1:0] aluSrcB, resultSrc, immSrc, regSrc, aluControl;

  multicycle_controller #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .aluFlags(aluFlags), .pcWrite(pcWrite), .irWrite(irWrite), .regWrite(regWrite),
    .memWrite(memWrite), .adrSrc(adrSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .resultSrc(resultSrc), .immSrc(immSrc), .regSrc(regSrc), .aluControl(aluControl),
    .instrDone(instrDone), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lat;
    int         nreg;
    int         nmem;
    int         npc;
    int         nill;
    bit         chk_alu;
    logic [1:0] alu;
    bit         chk_res;
    logic [1:0] res;
    bit         chk_adr;
    logic       adr;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] m_flags;
  logic [3:0] legal_cmds [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

  task automatic chk(string name, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ARM condition: pairs of codes share a base test, odd code inverts it
  function automatic bit cond_true(logic [3:0] cc, logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (cc[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cc == 4'hF) return 1'b0;
    return cc[0] ? !base : base;
  endfunction

  task automatic issue(logic [3:0] c, logic [1:0] o, logic [5:0] fn, logic [3:0] r,
                       logic [3:0] af);
    exp_t       e;
    bit         cex, legal, wr;
    logic [3:0] cmd;
    logic [1:0] ctl;
    cex = cond_true(c, m_flags);
    cmd = fn[4:1];
    e.lat = 0; e.nreg = 0; e.nmem = 0; e.npc = 0; e.nill = 0;
    e.chk_alu = 0; e.alu = 2'b00; e.chk_res = 0; e.res = 2'b00; e.chk_adr = 0; e.adr = 1'b0;
    case (o)
      2'b01: begin
        if (fn[0]) begin
          e.lat = 5; e.nreg = int'(cex); e.npc = int'(cex && r == 4'hF);
          e.chk_res = 1; e.res = 2'b01;
        end else begin
          e.lat = 4; e.nmem = int'(cex); e.chk_adr = 1; e.adr = 1'b1;
        end
      end
      2'b00: begin
        legal = (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010});
        case (cmd)
          4'b0010, 4'b1010: ctl = 2'b01;
          4'b0000:          ctl = 2'b10;
          4'b1100:          ctl = 2'b11;
          default:          ctl = 2'b00;
        endcase
        wr = cex && legal && (cmd != 4'b1010);
        e.lat = 4; e.nreg = int'(wr); e.npc = int'(wr && r == 4'hF); e.nill = int'(!legal);
        e.chk_alu = 1; e.alu = ctl; e.chk_res = 1; e.res = 2'b00;
        if (cex && (fn[0] || cmd == 4'b1010)) begin
          m_flags[3:2] = af[3:2];
          if (ctl == 2'b00 || ctl == 2'b01) m_flags[1:0] = af[1:0];
        end
      end
      2'b10: begin
        e.lat = 3; e.npc = int'(cex); e.chk_res = 1; e.res = 2'b10;
      end
      default: begin
        e.lat = 2; e.nill = 1; e.chk_res = 1; e.res = 2'b10;
      end
    endcase
    cond = c; op = o; funct = fn; rd = r; aluFlags = af;
    q.push_back(e);
    repeat (e.lat) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    int         cyc, nreg, nmem, npc, nill;
    logic [1:0] alu_seen;
    exp_t       e;
    cyc = 0; nreg = 0; nmem = 0; npc = 0; nill = 0; alu_seen = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (irWrite) begin
        cyc = 1; nreg = 0; nmem = 0; npc = 0; nill = 0;
        chk("fetch_pcWrite", int'(pcWrite), 1);
        chk("fetch_aluSrcA", int'(aluSrcA), 1);
        chk("fetch_aluSrcB", int'(aluSrcB), 2);
        chk("fetch_resultSrc", int'(resultSrc), 2);
        chk("fetch_adrSrc", int'(adrSrc), 0);
      end else begin
        cyc++;
        if (pcWrite) npc++;
      end
      if (regWrite) nreg++;
      if (memWrite) nmem++;
      if (illegal)  nill++;
      if (cyc == 3) alu_seen = aluControl;
      if (instrDone) begin
        if (q.size() == 0) begin
          chk("unexpected_instrDone", 1, 0);
        end else begin
          e = q.pop_front();
          chk("latency", cyc, e.lat);
          chk("regWrite_count", nreg, e.nreg);
          chk("memWrite_count", nmem, e.nmem);
          chk("pcWrite_count", npc, e.npc);
          chk("illegal_count", nill, e.nill);
          if (e.chk_alu) chk("aluControl_exec", int'(alu_seen), int'(e.alu));
          if (e.chk_res) chk("resultSrc_done", int'(resultSrc), int'(e.res));
          if (e.chk_adr) chk("adrSrc_done", int'(adrSrc), int'(e.adr));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1; cond = 4'hE; op = 2'b00; funct = 6'd0; rd = 4'd0; aluFlags = 4'd0;
    m_flags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pcWrite", int'(pcWrite), 0);
    chk("rst_irWrite", int'(irWrite), 0);
    chk("rst_instrDone", int'(instrDone), 0);
    chk("rst_aluSrcB", int'(aluSrcB), 2);
    reset = 1'b0;
    #1;
    chk("rel_irWrite", int'(irWrite), 1);
    chk("rel_pcWrite", int'(pcWrite), 1);

    // ADDS with all flags set, so the later reset must visibly clear them
    issue(4'hE, 2'b00, 6'b101001, 4'd1, 4'b1111);

    // LDR abandoned in MEMRD by reset
    cond = 4'hE; op = 2'b01; funct = 6'b011001; rd = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("memrd_adrSrc", int'(adrSrc), 1);
    reset = 1'b1;
    m_flags = 4'b0000;
    #1;
    chk("abort_pcWrite", int'(pcWrite), 0);
    chk("abort_irWrite", int'(irWrite), 0);
    chk("abort_regWrite", int'(regWrite), 0);
    chk("abort_memWrite", int'(memWrite), 0);
    chk("abort_instrDone", int'(instrDone), 0);
    chk("abort_illegal", int'(illegal), 0);
    chk("abort_adrSrc", int'(adrSrc), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rerel_irWrite", int'(irWrite), 1);
    chk("rerel_pcWrite", int'(pcWrite), 1);

    issue(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);   // BEQ after reset: Z=0, not taken
    issue(4'h2, 2'b10, 6'b000000, 4'd0, 4'b0000);   // BCS after reset: C=0, not taken
    issue(4'hE, 2'b00, 6'b101001, 4'd1, 4'b0110);   // ADDS R1
    issue(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);   // CMP
    issue(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);   // BEQ taken
    issue(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000);   // BNE not taken
    issue(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000);   // LDR
    issue(4'hE, 2'b01, 6'b011000, 4'd2, 4'b0000);   // STR
    issue(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000);   // op=11
    issue(4'hE, 2'b00, 6'b001110, 4'd4, 4'b0000);   // cmd=0111
    issue(4'hE, 2'b01, 6'b011001, 4'hF, 4'b0000);   // LDR PC
    issue(4'hF, 2'b00, 6'b101001, 4'd5, 4'b1111);   // never-condition ADDS

    for (int i = 0; i < 300; i++) begin
      logic [1:0] o;
      logic [5:0] fn;
      logic [3:0] c, r;
      o  = 2'($urandom_range(0, 3));
      fn = 6'($urandom);
      if (o == 2'b00 && $urandom_range(0, 3) != 0) fn[4:1] = legal_cmds[$urandom_range(0, 4)];
      c  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
      r  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
      issue(c, o, fn, r, 4'($urandom));
    end

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
